// File: rtl/control_sequencer_if.sv
// -----------------------------------------------------------------------------
// control_sequencer_if
//   Bundles the instruction/condition inputs and the control-word outputs of
//   the control sequencer so the datapath and sequencer share one connection.
//
//   Members
//     ir       [31:0] instruction register contents (opcode = ir[31:27])
//     con_ff          branch-condition flip-flop output
//     stop            external halt request
//     run             high while the sequencer is executing (T0..T7)
//     bus_src  [7:0]  one-hot {Cout,InPortout,MDRout,PCout,ZLowout,ZHighout,LOout,HIout}
//     reg_ctl  [5:0]  {GRA,GRB,GRC,Rin,Rout,BAout}
//     ld_en    [9:0]  {MAR,MDR,IR,Y,PC,Zlow,Zhigh,CON_in,LO,HI}
//     mem_ctl  [2:0]  {IncPC,Read,Write}
//     alu_op   [4:0]  ALU operation code
//     state    [3:0]  current sequencer state (debug)
//
//   Modports
//     master : the sequencer (drives control word, reads ir/con_ff/stop)
//     slave  : the datapath side (drives ir/con_ff/stop, reads control word)
// -----------------------------------------------------------------------------
interface control_sequencer_if;
  logic [31:0] ir;
  logic        con_ff;
  logic        stop;
  logic        run;
  logic [7:0]  bus_src;
  logic [5:0]  reg_ctl;
  logic [9:0]  ld_en;
  logic [2:0]  mem_ctl;
  logic [4:0]  alu_op;
  logic [3:0]  state;

  modport master (
    input  ir, con_ff, stop,
    output run, bus_src, reg_ctl, ld_en, mem_ctl, alu_op, state
  );

  modport slave (
    output ir, con_ff, stop,
    input  run, bus_src, reg_ctl, ld_en, mem_ctl, alu_op, state
  );
endinterface

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Moore-style hardwired control unit for a simple load/store CPU. Walks each
//   instruction through fetch (T0..T2) and an opcode-dependent execute tail
//   (T3..T7), emitting one control word per step.
//
//   Ports
//     clock  : single clock, all state changes on its rising edge
//     clear  : synchronous active-high reset, forces state RST
//     bus    : control_sequencer_if.master (ir, con_ff, stop in; run,
//              bus_src, reg_ctl, ld_en, mem_ctl, alu_op, state out)
//
//   Configuration
//     CTRL_MULDIV_EN : when defined, mul (01111) and div (10000) run a
//                      four-step execute that loads LO and HI. When undefined
//                      they behave as nop and the LO/HI load enables are tied 0.
// -----------------------------------------------------------------------------
module control_sequencer (
  input  logic                 clock,
  input  logic                 clear,
  control_sequencer_if.master  bus
);

  // State encoding is exported on bus.state for debug.
  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP,
    CL_RTYPE,
    CL_IMM,
    CL_LDI,
    CL_LD,
    CL_ST,
    CL_BR,
    CL_JR,
    CL_MULDIV,
    CL_HALT
  } iclass_t;

  // Opcodes
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_RLO  = 5'b00011;  // first R-type ALU opcode
  localparam logic [4:0] OP_RHI  = 5'b01011;  // last R-type ALU opcode
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
`ifdef CTRL_MULDIV_EN
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
`endif
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU codes used for address/immediate arithmetic
  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;

  // Bit positions inside each control field
  localparam int BUS_C    = 7;
  localparam int BUS_MDR  = 5;
  localparam int BUS_PC   = 4;
  localparam int BUS_ZLO  = 3;
  localparam int BUS_ZHI  = 2;

  localparam int REG_GRA  = 5;
  localparam int REG_GRB  = 4;
  localparam int REG_GRC  = 3;
  localparam int REG_RIN  = 2;
  localparam int REG_ROUT = 1;
  localparam int REG_BA   = 0;

  localparam int LD_MAR   = 9;
  localparam int LD_MDR   = 8;
  localparam int LD_IR    = 7;
  localparam int LD_Y     = 6;
  localparam int LD_PC    = 5;
  localparam int LD_ZLO   = 4;
  localparam int LD_ZHI   = 3;
  localparam int LD_CON   = 2;
  localparam int LD_LO    = 1;
  localparam int LD_HI    = 0;

  localparam int MEM_INC  = 2;
  localparam int MEM_RD   = 1;
  localparam int MEM_WR   = 0;

  // Without the multiply/divide option the LO/HI enables can never assert.
`ifdef CTRL_MULDIV_EN
  localparam logic [9:0] LD_EN_MASK = 10'h3FF;
`else
  localparam logic [9:0] LD_EN_MASK = 10'h3FC;
`endif

  state_t      state_q;
  state_t      state_d;
  iclass_t     iclass;
  logic [4:0]  opcode;
  logic [4:0]  imm_alu;
  logic        seq_done;

  logic [7:0]  bus_src_c;
  logic [5:0]  reg_ctl_c;
  logic [9:0]  ld_en_c;
  logic [2:0]  mem_ctl_c;
  logic [4:0]  alu_op_c;

  // Register fields of ir are consumed by the datapath, not by sequencing.
  logic unused_ir;
  assign unused_ir = ^bus.ir[26:0];

  assign opcode = bus.ir[31:27];

  // ---------------------------------------------------------------------------
  // Instruction classification
  // ---------------------------------------------------------------------------
  always_comb begin
    iclass  = CL_NOP;
    imm_alu = ALU_NONE;
    case (opcode)
      OP_LD:   iclass = CL_LD;
      OP_LDI:  iclass = CL_LDI;
      OP_ST:   iclass = CL_ST;
      OP_ADDI: begin iclass = CL_IMM; imm_alu = ALU_ADD; end
      OP_ANDI: begin iclass = CL_IMM; imm_alu = ALU_AND; end
      OP_ORI:  begin iclass = CL_IMM; imm_alu = ALU_OR;  end
`ifdef CTRL_MULDIV_EN
      OP_MUL,
      OP_DIV:  iclass = CL_MULDIV;
`endif
      OP_BR:   iclass = CL_BR;
      OP_JR:   iclass = CL_JR;
      OP_HALT: iclass = CL_HALT;
      default: begin
        // Contiguous R-type block; anything else (incl. nop) stays CL_NOP.
        if (opcode >= OP_RLO && opcode <= OP_RHI) begin
          iclass = CL_RTYPE;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. seq_done marks the last step of an instruction; stop is
  // only honoured there, so an instruction already underway always finishes.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    seq_done = 1'b0;
    case (state_q)
      // Leaving reset always starts a fetch; stop is not consulted here.
      ST_RST:  state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2: begin
        case (iclass)
          CL_NOP:  seq_done = 1'b1;
          CL_HALT: state_d  = ST_HALT;
          default: state_d  = ST_T3;
        endcase
      end
      ST_T3: begin
        if (iclass == CL_JR) seq_done = 1'b1;
        else                 state_d  = ST_T4;
      end
      ST_T4:   state_d = ST_T5;
      ST_T5: begin
        if (iclass == CL_RTYPE || iclass == CL_IMM || iclass == CL_LDI) begin
          seq_done = 1'b1;
        end else begin
          state_d = ST_T6;
        end
      end
      ST_T6: begin
        if (iclass == CL_BR || iclass == CL_MULDIV) seq_done = 1'b1;
        else                                        state_d  = ST_T7;
      end
      ST_T7:   seq_done = 1'b1;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase

    if (seq_done) begin
      state_d = bus.stop ? ST_HALT : ST_T0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control-word decode from state and ir (con_ff only gates the branch's PC
  // load in T6). Every field defaults to 0 so unlisted signals stay low.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus_src_c = '0;
    reg_ctl_c = '0;
    ld_en_c   = '0;
    mem_ctl_c = '0;
    alu_op_c  = ALU_NONE;

    case (state_q)
      ST_T0: begin
        bus_src_c[BUS_PC]  = 1'b1;
        ld_en_c[LD_MAR]    = 1'b1;
        mem_ctl_c[MEM_INC] = 1'b1;
      end

      ST_T1: begin
        mem_ctl_c[MEM_RD]  = 1'b1;
        ld_en_c[LD_MDR]    = 1'b1;
      end

      ST_T2: begin
        bus_src_c[BUS_MDR] = 1'b1;
        ld_en_c[LD_IR]     = 1'b1;
      end

      ST_T3: begin
        case (iclass)
          CL_RTYPE, CL_IMM: begin
            reg_ctl_c[REG_GRB]  = 1'b1;
            reg_ctl_c[REG_ROUT] = 1'b1;
            ld_en_c[LD_Y]       = 1'b1;
          end
          // Base-address path: BAout gives 0 for r0 so ldi/ld/st share it.
          CL_LDI, CL_LD, CL_ST: begin
            reg_ctl_c[REG_GRB]  = 1'b1;
            reg_ctl_c[REG_BA]   = 1'b1;
            ld_en_c[LD_Y]       = 1'b1;
          end
          CL_BR: begin
            reg_ctl_c[REG_GRA]  = 1'b1;
            reg_ctl_c[REG_ROUT] = 1'b1;
            ld_en_c[LD_CON]     = 1'b1;
          end
          CL_JR: begin
            reg_ctl_c[REG_GRA]  = 1'b1;
            reg_ctl_c[REG_ROUT] = 1'b1;
            ld_en_c[LD_PC]      = 1'b1;
          end
          CL_MULDIV: begin
            reg_ctl_c[REG_GRA]  = 1'b1;
            reg_ctl_c[REG_ROUT] = 1'b1;
            ld_en_c[LD_Y]       = 1'b1;
          end
          default: ;
        endcase
      end

      ST_T4: begin
        case (iclass)
          CL_RTYPE, CL_MULDIV: begin
            // R-type uses Rc as the second operand; mul/div use Rb.
            if (iclass == CL_RTYPE) reg_ctl_c[REG_GRC] = 1'b1;
            else                    reg_ctl_c[REG_GRB] = 1'b1;
            reg_ctl_c[REG_ROUT] = 1'b1;
            alu_op_c            = opcode;
            ld_en_c[LD_ZLO]     = 1'b1;
            ld_en_c[LD_ZHI]     = 1'b1;
          end
          CL_IMM: begin
            bus_src_c[BUS_C]    = 1'b1;
            alu_op_c            = imm_alu;
            ld_en_c[LD_ZLO]     = 1'b1;
          end
          CL_LDI, CL_LD, CL_ST: begin
            bus_src_c[BUS_C]    = 1'b1;
            alu_op_c            = ALU_ADD;
            ld_en_c[LD_ZLO]     = 1'b1;
          end
          CL_BR: begin
            bus_src_c[BUS_PC]   = 1'b1;
            ld_en_c[LD_Y]       = 1'b1;
          end
          default: ;
        endcase
      end

      ST_T5: begin
        case (iclass)
          CL_RTYPE, CL_IMM, CL_LDI: begin
            bus_src_c[BUS_ZLO]  = 1'b1;
            reg_ctl_c[REG_GRA]  = 1'b1;
            reg_ctl_c[REG_RIN]  = 1'b1;
          end
          CL_LD, CL_ST: begin
            bus_src_c[BUS_ZLO]  = 1'b1;
            ld_en_c[LD_MAR]     = 1'b1;
          end
          CL_BR: begin
            bus_src_c[BUS_C]    = 1'b1;
            alu_op_c            = ALU_ADD;
            ld_en_c[LD_ZLO]     = 1'b1;
          end
          CL_MULDIV: begin
            bus_src_c[BUS_ZLO]  = 1'b1;
            ld_en_c[LD_LO]      = 1'b1;
          end
          default: ;
        endcase
      end

      ST_T6: begin
        case (iclass)
          CL_LD: begin
            mem_ctl_c[MEM_RD]   = 1'b1;
            ld_en_c[LD_MDR]     = 1'b1;
          end
          // Store data comes from Ra over the bus; MDR must not read memory.
          CL_ST: begin
            reg_ctl_c[REG_GRA]  = 1'b1;
            reg_ctl_c[REG_ROUT] = 1'b1;
            ld_en_c[LD_MDR]     = 1'b1;
          end
          CL_BR: begin
            bus_src_c[BUS_ZLO]  = 1'b1;
            ld_en_c[LD_PC]      = bus.con_ff;
          end
          CL_MULDIV: begin
            bus_src_c[BUS_ZHI]  = 1'b1;
            ld_en_c[LD_HI]      = 1'b1;
          end
          default: ;
        endcase
      end

      ST_T7: begin
        case (iclass)
          CL_LD: begin
            bus_src_c[BUS_MDR]  = 1'b1;
            reg_ctl_c[REG_GRA]  = 1'b1;
            reg_ctl_c[REG_RIN]  = 1'b1;
          end
          CL_ST:   mem_ctl_c[MEM_WR] = 1'b1;
          default: ;
        endcase
      end

      default: ;  // RST, HALT: everything low
    endcase
  end

  assign bus.bus_src = bus_src_c;
  assign bus.reg_ctl = reg_ctl_c;
  assign bus.ld_en   = ld_en_c & LD_EN_MASK;
  assign bus.mem_ctl = mem_ctl_c;
  assign bus.alu_op  = alu_op_c;
  assign bus.state   = state_q;
  assign bus.run     = (state_q != ST_RST) && (state_q != ST_HALT);

endmodule
